// File: rtl/shake_pkg.sv
// ============================================================================
//  Module      : shake_pkg
//  Description : Shared constants and state type for the SHAKE256 datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shake_pkg;

    localparam int       RATE_BYTES        = 136;
    localparam bit [7:0] SHAKE_DOMAIN_BYTE = 8'h1F;
    localparam bit [7:0] PAD_FINAL_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2
    } pad_state_t;

endpackage

`default_nettype wire

// File: rtl/shake_pad.sv
// ============================================================================
//  Module      : shake_pad
//  Description : Byte-stream to rate-block packer with SHAKE multi-rate padding.
//                Optional macro SHAKE_PAD_BLKCNT_EN adds the blk_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shake_pad
    import shake_pkg::*;
#(
    parameter int WIDTH_OUT = 1088
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_keep,
    input  logic                 in_last,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [WIDTH_OUT-1:0] blk_data,
    output logic                 blk_last,
    output logic                 busy
`ifdef SHAKE_PAD_BLKCNT_EN
    ,
    output logic [15:0]          blk_count
`endif
);

    localparam int RATE_BYTES = WIDTH_OUT / 8;

    pad_state_t           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [WIDTH_OUT-1:0] buf_q, buf_d;
    logic                 pad_pend_q, pad_pend_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
`ifdef SHAKE_PAD_BLKCNT_EN
    logic [15:0]          blk_count_q, blk_count_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            buf_q       <= '0;
            pad_pend_q  <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SHAKE_PAD_BLKCNT_EN
            blk_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            pad_pend_q  <= pad_pend_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
`ifdef SHAKE_PAD_BLKCNT_EN
            blk_count_q <= blk_count_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        pad_pend_d  = pad_pend_q;
        last_d      = last_q;
        busy_d      = busy_q;
`ifdef SHAKE_PAD_BLKCNT_EN
        blk_count_d = blk_count_q;
`endif
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    busy_d = 1'b1;
                    if (in_keep) begin
                        for (int i = 0; i < RATE_BYTES; i++) begin
                            if (cnt_q == 8'(i)) begin
                                buf_d[WIDTH_OUT-1-8*i -: 8] = in_data;
                            end
                        end
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == 8'(RATE_BYTES - 1)) begin
                            // A message ending exactly on a block boundary still owes a pad-only block.
                            state_d    = EMIT;
                            last_d     = 1'b0;
                            pad_pend_d = in_last;
                        end else if (in_last) begin
                            state_d = PAD;
                        end
                    end else if (in_last) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                for (int i = 0; i < RATE_BYTES; i++) begin
                    if (cnt_q == 8'(i)) begin
                        buf_d[WIDTH_OUT-1-8*i -: 8] = buf_q[WIDTH_OUT-1-8*i -: 8] | SHAKE_DOMAIN_BYTE;
                    end
                end
                // OR onto buf_d so a domain byte landing in the last lane merges into 0x9F.
                buf_d[7:0] = buf_d[7:0] | PAD_FINAL_BYTE;
                state_d    = EMIT;
                last_d     = 1'b1;
            end
            EMIT: begin
                if (blk_ready) begin
                    buf_d  = '0;
                    cnt_d  = '0;
                    last_d = 1'b0;
                    if (last_q) begin
                        busy_d = 1'b0;
                    end
`ifdef SHAKE_PAD_BLKCNT_EN
                    if (last_q) begin
                        blk_count_d = '0;
                    end else if (blk_count_q != 16'hFFFF) begin
                        blk_count_d = blk_count_q + 16'd1;
                    end
`endif
                    if (pad_pend_q) begin
                        state_d    = PAD;
                        pad_pend_d = 1'b0;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign in_ready  = (state_q == FILL) && !reset;
    assign blk_valid = (state_q == EMIT);
    assign blk_last  = (state_q == EMIT) && last_q;
    assign blk_data  = buf_q;
    assign busy      = busy_q || (in_valid && in_ready);
`ifdef SHAKE_PAD_BLKCNT_EN
    assign blk_count = blk_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shake_pad.sv
// ============================================================================
//  Module      : tb_shake_pad
//  Description : Randomized self-checking bench for shake_pad against a
//                message-level padding model (SHAKE_PAD_BLKCNT_EN aware).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shake_pad;

    localparam int W  = 1088;
    localparam int NB = W / 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
        logic [15:0]  idx;
    } blk_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_keep;
    logic         in_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [W-1:0] blk_data;
    logic         blk_last;
    logic         busy;
`ifdef SHAKE_PAD_BLKCNT_EN
    logic [15:0]  blk_count;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] msg[$];
    blk_t       expq[$];

    always #5 clk = ~clk;

    shake_pad #(.WIDTH_OUT(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .busy      (busy)
`ifdef SHAKE_PAD_BLKCNT_EN
        ,
        .blk_count (blk_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected blocks straight from the padding rule: chunk into 136 bytes,
    // then a final block with 0x1F after the tail and 0x80 in the last lane.
    task automatic build_expected();
        int   L     = msg.size();
        int   nfull = L / NB;
        int   r     = L % NB;
        blk_t e;
        expq.delete();
        for (int b = 0; b < nfull; b++) begin
            e = '0;
            for (int j = 0; j < NB; j++) e.d[W-1-8*j -: 8] = msg[b*NB+j];
            e.last = 1'b0;
            e.idx  = 16'(b);
            expq.push_back(e);
        end
        e = '0;
        for (int j = 0; j < r; j++) e.d[W-1-8*j -: 8] = msg[nfull*NB+j];
        e.d[W-1-8*r -: 8] = e.d[W-1-8*r -: 8] | 8'h1F;
        e.d[7:0]          = e.d[7:0] | 8'h80;
        e.last = 1'b1;
        e.idx  = 16'(nfull);
        expq.push_back(e);
    endtask

    task automatic check_block(input blk_t e);
        int k = 0;
        for (int j = NB - 1; j >= 0; j--) begin
            if (blk_data[W-1-8*j -: 8] !== e.d[W-1-8*j -: 8]) k = j;
        end
        check($sformatf("blk_data[%0d]", k), {24'd0, blk_data[W-1-8*k -: 8]}, {24'd0, e.d[W-1-8*k -: 8]});
        check("blk_last", {31'd0, blk_last}, {31'd0, e.last});
`ifdef SHAKE_PAD_BLKCNT_EN
        check("blk_count", {16'd0, blk_count}, {16'd0, e.idx});
`endif
    endtask

    // Drives msg (plus optional terminator beat) and scores every block shown.
    task automatic run_msg(input int term_sep, input int rmode, input int gaps);
        int L        = msg.size();
        int nbeats   = L + term_sep;
        int pos      = 0;
        int cyc      = 0;
        int last_cyc = -1;
        int kind;
        bit lat_done = 1'b0;
        bit fin      = 1'b0;
        build_expected();
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            kind = 0;
            if (pos < nbeats && gaps != 0 && $urandom_range(0, 3) == 0) kind = int'($urandom_range(1, 2));
            in_valid = 1'b0;
            in_keep  = 1'b0;
            in_last  = 1'b0;
            in_data  = 8'($urandom);
            if (pos < nbeats) begin
                if (kind == 0) begin
                    in_valid = 1'b1;
                    if (pos < L) begin
                        in_data = msg[pos];
                        in_keep = 1'b1;
                        in_last = (term_sep == 0) && (pos == L - 1);
                    end else begin
                        in_last = 1'b1;
                    end
                end else if (kind == 2) begin
                    in_valid = 1'b1;
                end
            end
            case (rmode)
                0:       blk_ready = 1'b1;
                1:       blk_ready = cyc[0];
                default: blk_ready = 1'($urandom_range(0, 1));
            endcase
            if (blk_valid) begin
                check("in_ready_in_emit", {31'd0, in_ready}, 32'd0);
                if (expq.size() == 0) begin
                    check("unexpected_blk", {31'd0, blk_valid}, 32'd0);
                end else begin
                    check_block(expq[0]);
                    if (last_cyc >= 0 && !lat_done) begin
                        lat_done = 1'b1;
                        check("valid_latency", cyc - last_cyc,
                              (L > 0 && L % NB == 0 && term_sep == 0) ? 1 : 2);
                    end
                    if (blk_ready) begin
                        check("busy_at_hs", {31'd0, busy}, 32'd1);
                        if (expq[0].last) fin = 1'b1;
                        void'(expq.pop_front());
                    end
                end
            end
            if (in_valid && in_ready && kind == 0) begin
                pos++;
                if (pos == nbeats) last_cyc = cyc;
            end
        end
        in_valid = 1'b0;
        if (!fin) begin
            check("timeout_blocks_left", expq.size(), 0);
        end else begin
            @(negedge clk);
            check("busy_after_last", {31'd0, busy}, 32'd0);
            check("valid_after_last", {31'd0, blk_valid}, 32'd0);
`ifdef SHAKE_PAD_BLKCNT_EN
            check("count_cleared", {16'd0, blk_count}, 32'd0);
`endif
        end
    endtask

    task automatic load_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_keep   = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
        blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_blk_valid", {31'd0, blk_valid}, 32'd0);
        check("post_rst_blk_last", {31'd0, blk_last}, 32'd0);
        check("post_rst_blk_data_nz", {31'd0, |blk_data}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        msg.delete();
        run_msg(1, 0, 0);
        load_abc();
        run_msg(0, 0, 0);
        msg.delete();
        for (int i = 0; i < 135; i++) msg.push_back(8'hAA);
        run_msg(0, 0, 0);
        msg.delete();
        for (int i = 0; i < 136; i++) msg.push_back(8'h55);
        run_msg(0, 0, 0);
        msg.delete();
        for (int i = 0; i < 300; i++) msg.push_back(8'($urandom));
        run_msg(0, 1, 0);

        // Reset while a full block waits in EMIT with a pad block pending.
        begin
            int p = 0;
            blk_ready = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (blk_valid) break;
                in_valid = (p < NB);
                in_keep  = 1'b1;
                in_data  = 8'($urandom);
                in_last  = (p == NB - 1);
                if (in_valid && in_ready) p++;
            end
            in_valid = 1'b0;
            check("rst_test_in_emit", {31'd0, blk_valid}, 32'd1);
            reset = 1'b1;
            @(negedge clk);
            check("emit_rst_blk_valid", {31'd0, blk_valid}, 32'd0);
            check("emit_rst_in_ready", {31'd0, in_ready}, 32'd0);
            reset = 1'b0;
            @(negedge clk);
            check("emit_rst_after_in_ready", {31'd0, in_ready}, 32'd1);
            check("emit_rst_after_busy", {31'd0, busy}, 32'd0);
            blk_ready = 1'b1;
            repeat (3) @(negedge clk);
            check("emit_rst_pend_dropped", {31'd0, blk_valid}, 32'd0);
            load_abc();
            run_msg(0, 0, 0);
        end

        for (int t = 0; t < 12; t++) begin
            int L = int'($urandom_range(0, 420));
            msg.delete();
            for (int i = 0; i < L; i++) msg.push_back(8'($urandom));
            run_msg((L == 0) ? 1 : int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
